// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the logic that feeds it.
//   DATA_W      : ALU datapath width.
//   alu_op_e    : ALU opcode encoding.
//   alu_movi_e  : operand-B source select (register, memory, immediate).
//   OP_MUL      : the only opcode that returns two result beats.
//   arb_state_e : state encoding of the alu_arbiter sequencer.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        MUL  = 4'd2,
        SRL  = 4'd3,
        SLL  = 4'd4,
        ROR  = 4'd5,
        ROL  = 4'd6,
        NOT  = 4'd7,
        AND  = 4'd8,
        OR   = 4'd9,
        XOR  = 4'd10,
        NAND = 4'd11,
        NOR  = 4'd12,
        XNOR = 4'd13,
        INC  = 4'd14,
        DEC  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        REG = 2'd0,
        MEM = 2'd1,
        IMM = 2'd2
    } alu_movi_e;

    localparam alu_op_e OP_MUL = MUL;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts one position after
// last_grant and wraps modulo N; the first requester found wins.
//   req        in  N    request vector
//   last_grant in  IDW  index of the previously served requester
//   grant      out N    one-hot grant (all zero when req is all zero)
//   grant_idx  out IDW  index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    int   cand;
    logic found;

    // Walk the N positions after last_grant in order; only the first hit
    // is recorded, so the grant stays one-hot.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(last_grant) + off) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between N requesters. One operation at a time is accepted
// round-robin, issued to the ALU with a single ACT strobe, its result beats
// are collected (two for a multiply) and returned as a 64-bit response
// tagged with the requester index, held until the consumer takes it.
//
// Ports
//   CLK, RST                 clock / synchronous active-high reset
//   REQ_VLD, REQ_RDY         per-requester valid / one-hot accept pulse
//   REQ_OP, REQ_MOVI         per-requester opcode and operand-B select
//   REQ_A/B/MEM/IMM          per-requester operands
//   ALU_ACT                  one-cycle start strobe to the ALU
//   ALU_OP, ALU_MOVI         command to the ALU
//   ALU_REG_A/REG_B/MEM/IMM  operands to the ALU
//   ALU_DATA, ALU_RDY, ALU_VLD  result beat, ALU idle, beat valid
//   RSP_VLD, RSP_RDY         response handshake
//   RSP_ID, RSP_DATA, RSP_MUL   requester index, 64-bit result, multiply flag
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic                       CLK,
    input  logic                       RST,

    input  logic [N-1:0]               REQ_VLD,
    output logic [N-1:0]               REQ_RDY,
    input  logic [N-1:0][3:0]          REQ_OP,
    input  logic [N-1:0][1:0]          REQ_MOVI,
    input  logic [N-1:0][DATA_W-1:0]   REQ_A,
    input  logic [N-1:0][DATA_W-1:0]   REQ_B,
    input  logic [N-1:0][DATA_W-1:0]   REQ_MEM,
    input  logic [N-1:0][DATA_W-1:0]   REQ_IMM,

    output logic                       ALU_ACT,
    output logic [3:0]                 ALU_OP,
    output logic [1:0]                 ALU_MOVI,
    output logic [DATA_W-1:0]          ALU_REG_A,
    output logic [DATA_W-1:0]          ALU_REG_B,
    output logic [DATA_W-1:0]          ALU_MEM,
    output logic [DATA_W-1:0]          ALU_IMM,
    input  logic [DATA_W-1:0]          ALU_DATA,
    input  logic                       ALU_RDY,
    input  logic                       ALU_VLD,

    output logic                       RSP_VLD,
    input  logic                       RSP_RDY,
    output logic [IDW-1:0]             RSP_ID,
    output logic [2*DATA_W-1:0]        RSP_DATA,
    output logic                       RSP_MUL
);

    arb_state_e          state;
    arb_state_e          state_nxt;

    logic [N-1:0]        grant;
    logic [IDW-1:0]      grant_idx;
    logic [IDW-1:0]      last_grant;
    logic                accept;

    alu_op_e             cmd_op;
    logic [1:0]          cmd_movi;
    logic [DATA_W-1:0]   cmd_a;
    logic [DATA_W-1:0]   cmd_b;
    logic [DATA_W-1:0]   cmd_mem;
    logic [DATA_W-1:0]   cmd_imm;
    logic [IDW-1:0]      cmd_id;
    logic                is_mul;
    logic                beat;
    logic [2*DATA_W-1:0] rsp_data;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_rr (
        .req        (REQ_VLD),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobes. The accept is suppressed while RST is high
    // because the command register would not capture it, so the requester
    // must not see a handshake that is then lost.
    always_comb begin
        state_nxt = state;
        REQ_RDY   = '0;
        ALU_ACT   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (ALU_RDY && (|REQ_VLD) && !RST) begin
                    REQ_RDY   = grant;
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ALU_ACT   = 1'b1;
                state_nxt = COLLECT;
            end
            COLLECT: begin
                if (ALU_VLD && (beat || !is_mul)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (RSP_RDY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command register, beat collection and round-robin pointer. The command
    // register only loads on accept, so the ALU inputs hold their last values
    // through IDLE and RESP. The response is built from registered beats, so
    // a beat never reaches RSP_DATA in the cycle it arrives.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_op     <= ADD;
            cmd_movi   <= '0;
            cmd_a      <= '0;
            cmd_b      <= '0;
            cmd_mem    <= '0;
            cmd_imm    <= '0;
            cmd_id     <= '0;
            is_mul     <= 1'b0;
            beat       <= 1'b0;
            rsp_data   <= '0;
            last_grant <= IDW'(N - 1);
        end else begin
            if (accept) begin
                cmd_op   <= alu_op_e'(REQ_OP[grant_idx]);
                cmd_movi <= REQ_MOVI[grant_idx];
                cmd_a    <= REQ_A[grant_idx];
                cmd_b    <= REQ_B[grant_idx];
                cmd_mem  <= REQ_MEM[grant_idx];
                cmd_imm  <= REQ_IMM[grant_idx];
                cmd_id   <= grant_idx;
            end
            if (state == ISSUE) begin
                is_mul <= (cmd_op == OP_MUL);
                beat   <= 1'b0;
            end
            if (state == COLLECT && ALU_VLD) begin
                if (!beat) begin
                    rsp_data[DATA_W-1:0]        <= ALU_DATA;
                    rsp_data[2*DATA_W-1:DATA_W] <= '0;
                    beat                        <= 1'b1;
                end else begin
                    rsp_data[2*DATA_W-1:DATA_W] <= ALU_DATA;
                end
            end
            if (state == RESP && RSP_RDY) begin
                last_grant <= cmd_id;
            end
        end
    end

    assign ALU_OP    = cmd_op;
    assign ALU_MOVI  = cmd_movi;
    assign ALU_REG_A = cmd_a;
    assign ALU_REG_B = cmd_b;
    assign ALU_MEM   = cmd_mem;
    assign ALU_IMM   = cmd_imm;

    assign RSP_VLD   = (state == RESP);
    assign RSP_ID    = cmd_id;
    assign RSP_DATA  = rsp_data;
    assign RSP_MUL   = is_mul;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with N=2. A small behavioural ALU answers
// each ACT with one result beat on the following cycle, plus a second beat
// for a multiply. Inputs are driven and outputs sampled just after the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N   = 2;
    localparam int IDW = 1;

    logic                   clk;
    logic                   rst;
    logic [N-1:0]           req_vld;
    logic [N-1:0]           req_rdy;
    logic [N-1:0][3:0]      req_op;
    logic [N-1:0][1:0]      req_movi;
    logic [N-1:0][31:0]     req_a;
    logic [N-1:0][31:0]     req_b;
    logic [N-1:0][31:0]     req_mem;
    logic [N-1:0][31:0]     req_imm;
    logic                   alu_act;
    logic [3:0]             alu_op;
    logic [1:0]             alu_movi;
    logic [31:0]            alu_reg_a;
    logic [31:0]            alu_reg_b;
    logic [31:0]            alu_mem;
    logic [31:0]            alu_imm;
    logic [31:0]            alu_data;
    logic                   alu_rdy;
    logic                   rsp_vld;
    logic                   rsp_rdy;
    logic [IDW-1:0]         rsp_id;
    logic [63:0]            rsp_data;
    logic                   rsp_mul;

    logic                   m_vld;
    logic                   m_beat;
    logic                   m_mul;
    logic [31:0]            m_opb;
    logic [63:0]            m_prod;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    alu_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ_VLD   (req_vld),
        .REQ_RDY   (req_rdy),
        .REQ_OP    (req_op),
        .REQ_MOVI  (req_movi),
        .REQ_A     (req_a),
        .REQ_B     (req_b),
        .REQ_MEM   (req_mem),
        .REQ_IMM   (req_imm),
        .ALU_ACT   (alu_act),
        .ALU_OP    (alu_op),
        .ALU_MOVI  (alu_movi),
        .ALU_REG_A (alu_reg_a),
        .ALU_REG_B (alu_reg_b),
        .ALU_MEM   (alu_mem),
        .ALU_IMM   (alu_imm),
        .ALU_DATA  (alu_data),
        .ALU_RDY   (alu_rdy),
        .ALU_VLD   (m_vld),
        .RSP_VLD   (rsp_vld),
        .RSP_RDY   (rsp_rdy),
        .RSP_ID    (rsp_id),
        .RSP_DATA  (rsp_data),
        .RSP_MUL   (rsp_mul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: beat 0 one cycle after ACT, beat 1 right after for MUL.
    always @(posedge clk) begin
        if (rst) begin
            m_vld  <= 1'b0;
            m_beat <= 1'b0;
            m_mul  <= 1'b0;
        end else if (alu_act) begin
            m_vld  <= 1'b1;
            m_beat <= 1'b0;
            m_mul  <= (alu_op == MUL);
        end else if (m_vld && m_mul && !m_beat) begin
            m_beat <= 1'b1;
        end else begin
            m_vld  <= 1'b0;
            m_beat <= 1'b0;
        end
    end

    // Result is combinational on the command the arbiter presents.
    always_comb begin
        m_opb    = alu_reg_b;
        if (alu_movi == 2'd1) m_opb = alu_mem;
        if (alu_movi == 2'd2) m_opb = alu_imm;
        m_prod   = {32'b0, alu_reg_a} * {32'b0, m_opb};
        alu_data = alu_reg_a ^ m_opb;
        case (alu_op)
            ADD:     alu_data = alu_reg_a + m_opb;
            SUB:     alu_data = alu_reg_a - m_opb;
            MUL:     alu_data = m_beat ? m_prod[63:32] : m_prod[31:0];
            default: alu_data = alu_reg_a ^ m_opb;
        endcase
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Ticks until RSP_VLD is seen or the budget runs out.
    task automatic wait_rsp;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (rsp_vld === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (req_rdy !== 2'b00 || alu_act !== 1'b0 || rsp_vld !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_strobes: req_rdy=%b alu_act=%b rsp_vld=%b, expected 00/0/0", req_rdy, alu_act, rsp_vld);
        end
        n_checks++;
        if (rsp_data !== 64'd0 || rsp_id !== 1'b0 || rsp_mul !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_rsp: data=%h id=%0d mul=%b, expected 0/0/0", rsp_data, rsp_id, rsp_mul);
        end
        n_checks++;
        if (alu_op !== 4'd0 || alu_movi !== 2'd0 || alu_reg_a !== 32'd0 || alu_imm !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_alu_cmd: op=%0d movi=%0d a=%h imm=%h, expected all 0", alu_op, alu_movi, alu_reg_a, alu_imm);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_add;
        tick();
        req_op[0] = ADD; req_movi[0] = 2'd0; req_a[0] = 32'd5; req_b[0] = 32'd7;
        req_vld = 2'b01;
        rsp_rdy = 1'b1;
        #1;
        n_checks++;
        if (req_rdy !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL add_accept: req_rdy=%b expected 01", req_rdy);
        end
        tick();
        req_vld = 2'b00;
        n_checks++;
        if (alu_act !== 1'b1 || req_rdy !== 2'b00 || alu_op !== 4'd0 || alu_reg_a !== 32'd5) begin
            n_fail++;
            $display("[TB] FAIL add_issue: act=%b req_rdy=%b op=%0d a=%0d expected 1/00/0/5", alu_act, req_rdy, alu_op, alu_reg_a);
        end
        tick();
        n_checks++;
        if (alu_act !== 1'b0 || rsp_vld !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL add_collect: act=%b rsp_vld=%b expected 0/0", alu_act, rsp_vld);
        end
        tick();
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_data !== 64'd12 || rsp_id !== 1'b0 || rsp_mul !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL add_resp: vld=%b data=%h id=%0d mul=%b expected 1/12/0/0", rsp_vld, rsp_data, rsp_id, rsp_mul);
        end
    endtask

    task automatic test_multiply;
        tick();
        req_op[1] = MUL; req_movi[1] = 2'd2; req_a[1] = 32'h0001_0000;
        req_b[1] = 32'h0000_1234; req_imm[1] = 32'h0002_0000;
        req_vld = 2'b10;
        #1;
        n_checks++;
        if (req_rdy !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL mul_accept: req_rdy=%b expected 10", req_rdy);
        end
        tick();
        req_vld = 2'b00;
        n_checks++;
        if (alu_act !== 1'b1 || alu_op !== 4'd2 || alu_movi !== 2'd2 || alu_imm !== 32'h0002_0000) begin
            n_fail++;
            $display("[TB] FAIL mul_issue: act=%b op=%0d movi=%0d imm=%h expected 1/2/2/00020000", alu_act, alu_op, alu_movi, alu_imm);
        end
        tick();
        tick();
        n_checks++;
        if (rsp_vld !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mul_early_rsp: rsp_vld=%b at T+3 expected 0", rsp_vld);
        end
        tick();
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_data !== 64'h0000_0002_0000_0000 || rsp_mul !== 1'b1 || rsp_id !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mul_resp: vld=%b data=%h mul=%b id=%0d expected 1/0000000200000000/1/1", rsp_vld, rsp_data, rsp_mul, rsp_id);
        end
    endtask

    task automatic test_contention;
        int acc_prev;
        int acc_now;
        logic [1:0]  exp_rdy;
        logic [63:0] exp_data;
        acc_prev = 0;
        tick();
        req_op[0] = ADD; req_movi[0] = 2'd0; req_a[0] = 32'd1;  req_b[0] = 32'd2;
        req_op[1] = SUB; req_movi[1] = 2'd0; req_a[1] = 32'd10; req_b[1] = 32'd3;
        req_vld = 2'b11;
        rsp_rdy = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_data = (k % 2 == 0) ? 64'd3 : 64'd7;
            for (int c = 0; c < 12; c++) begin
                if (req_rdy !== 2'b00) break;
                tick();
            end
            acc_now = cyc;
            n_checks++;
            if (req_rdy !== exp_rdy) begin
                n_fail++;
                $display("[TB] FAIL contention_grant%0d: req_rdy=%b expected %b", k, req_rdy, exp_rdy);
            end
            if (k > 0) begin
                n_checks++;
                if (acc_now - acc_prev !== 4) begin
                    n_fail++;
                    $display("[TB] FAIL contention_spacing%0d: %0d cycles expected 4", k, acc_now - acc_prev);
                end
            end
            acc_prev = acc_now;
            wait_rsp();
            n_checks++;
            if (rsp_vld !== 1'b1 || rsp_id !== exp_rdy[1] || rsp_data !== exp_data) begin
                n_fail++;
                $display("[TB] FAIL contention_rsp%0d: vld=%b id=%0d data=%0d expected 1/%0d/%0d", k, rsp_vld, rsp_id, rsp_data, exp_rdy[1], exp_data);
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        int stall_bad;
        stall_bad = 0;
        rsp_rdy   = 1'b0;
        req_a[0]  = 32'd100;
        req_b[0]  = 32'd23;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (req_rdy !== 2'b00) break;
            tick();
        end
        n_checks++;
        if (req_rdy !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL bp_accept: req_rdy=%b expected 01", req_rdy);
        end
        wait_rsp();
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (rsp_vld !== 1'b1 || rsp_data !== 64'd123 || req_rdy !== 2'b00 || alu_act !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL bp_stall%0d: vld=%b data=%0d req_rdy=%b act=%b expected 1/123/00/0", c, rsp_vld, rsp_data, req_rdy, alu_act);
            end
            tick();
        end
        rsp_rdy = 1'b1;
        tick();
        n_checks++;
        if (rsp_vld !== 1'b0 || req_rdy !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL bp_release: vld=%b req_rdy=%b expected 0/10", rsp_vld, req_rdy);
        end
        tick();
        req_vld = 2'b00;
        wait_rsp();
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 64'd7) begin
            n_fail++;
            $display("[TB] FAIL bp_next_rsp: vld=%b id=%0d data=%0d expected 1/1/7", rsp_vld, rsp_id, rsp_data);
        end
    endtask

    task automatic test_reset_mid_mul;
        tick();
        req_op[1] = MUL; req_movi[1] = 2'd0; req_a[1] = 32'd3; req_b[1] = 32'd5;
        req_vld = 2'b10;
        #1;
        n_checks++;
        if (req_rdy !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL rmm_accept: req_rdy=%b expected 10", req_rdy);
        end
        tick();
        req_vld = 2'b00;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (rsp_vld !== 1'b0 || rsp_data !== 64'd0 || rsp_mul !== 1'b0 || alu_op !== 4'd0 || req_rdy !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL rmm_after_reset: vld=%b data=%h mul=%b op=%0d req_rdy=%b expected 0/0/0/0/00", rsp_vld, rsp_data, rsp_mul, alu_op, req_rdy);
        end
        rst = 1'b0;
        req_op[0] = ADD; req_movi[0] = 2'd0; req_a[0] = 32'd8; req_b[0] = 32'd9;
        req_vld = 2'b11;
        #1;
        n_checks++;
        if (req_rdy !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL rmm_first_grant: req_rdy=%b expected 01", req_rdy);
        end
        tick();
        req_vld = 2'b00;
        wait_rsp();
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 64'd17) begin
            n_fail++;
            $display("[TB] FAIL rmm_rsp: vld=%b id=%0d data=%0d expected 1/0/17", rsp_vld, rsp_id, rsp_data);
        end
    endtask

    task automatic test_alu_busy;
        tick();
        alu_rdy   = 1'b0;
        req_op[0] = SUB; req_movi[0] = 2'd0; req_a[0] = 32'd20; req_b[0] = 32'd4;
        req_vld   = 2'b01;
        #1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (req_rdy !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL busy_hold%0d: req_rdy=%b expected 00", c, req_rdy);
            end
            tick();
        end
        alu_rdy = 1'b1;
        #1;
        n_checks++;
        if (req_rdy !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL busy_release: req_rdy=%b expected 01", req_rdy);
        end
        tick();
        req_vld = 2'b00;
        wait_rsp();
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 64'd16) begin
            n_fail++;
            $display("[TB] FAIL busy_rsp: vld=%b id=%0d data=%0d expected 1/0/16", rsp_vld, rsp_id, rsp_data);
        end
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        req_vld  = '0;
        req_op   = '0;
        req_movi = '0;
        req_a    = '0;
        req_b    = '0;
        req_mem  = '0;
        req_imm  = '0;
        alu_rdy  = 1'b1;
        rsp_rdy  = 1'b1;
        $display("[TB] starting alu_arbiter directed tests");
        test_reset();
        test_single_add();
        test_multiply();
        test_contention();
        test_backpressure();
        test_reset_mid_mul();
        test_alu_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
